// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue sequencer: FSM state, opcodes and instruction layout.
package alu_issue_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_AND    = 3'b010,
        OP_OR     = 3'b011,
        OP_ROL_RS = 3'b100,
        OP_ASR_RT = 3'b101,
        OP_EQ     = 3'b110,
        OP_GT     = 3'b111
    } opcode_e;

    // Field order fixes the bit positions: ldi[9] sel[8:6] rd[5:4] rs[3:2] rt[1:0].
    // For load-immediate the immediate is {rs_idx, rt_idx} = instr[3:0].
    typedef struct packed {
        logic       ldi;
        logic [2:0] sel;
        logic [1:0] rd_idx;
        logic [1:0] rs_idx;
        logic [1:0] rt_idx;
    } instr_t;

    localparam int INSTR_W = $bits(instr_t);

endpackage

// File: rtl/alu_issue_regfile.sv
// Architectural register file: one write port, combinational rs/rt/debug read ports.
module alu_issue_regfile #(
    parameter int NREG = 4,
    parameter int DW   = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [1:0]    wr_idx,
    input  logic [DW-1:0] wr_data,
    input  logic [1:0]    rs_idx,
    input  logic [1:0]    rt_idx,
    input  logic [1:0]    dbg_idx,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic [DW-1:0] dbg_data
);

    logic [NREG-1:0][DW-1:0] regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '0;
        else if (we)
            regs[wr_idx] <= wr_data;
    end

    assign rs_data  = regs[rs_idx];
    assign rt_data  = regs[rt_idx];
    assign dbg_data = regs[dbg_idx];

endmodule

// File: rtl/alu_issue_sequencer.sv
// Issue front end for the 4-bit ALU: accept, drive registered operands, write result back.
// `define ALU_ISSUE_LDI_EN enables the load-immediate path selected by instr[9].
module alu_issue_sequencer
    import alu_issue_pkg::*;
#(
    parameter int NREG = 4,
    parameter int DW   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [DW-1:0]      alu_rs,
    output logic [DW-1:0]      alu_rt,
    output logic [2:0]         alu_sel,
    input  logic [DW-1:0]      alu_rd,
    output logic               wb_valid,
    output logic [1:0]         wb_idx,
    output logic [DW-1:0]      wb_data,
    input  logic [1:0]         dbg_idx,
    output logic [DW-1:0]      dbg_data
);

    state_e        state, state_nx;
    instr_t        dec;
    logic          accept, commit, is_alu;
    logic [1:0]    rd_q;
    logic [DW-1:0] rs_data, rt_data, wr_data;

    assign dec = instr_t'(instr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        commit      = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept   = 1'b1;
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                commit   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef ALU_ISSUE_LDI_EN
    logic          ldi_q;
    logic [DW-1:0] imm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ldi_q <= 1'b0;
            imm_q <= '0;
        end else if (accept) begin
            ldi_q <= dec.ldi;
            imm_q <= DW'({dec.rs_idx, dec.rt_idx});
        end
    end

    assign is_alu  = !dec.ldi;
    assign wr_data = ldi_q ? imm_q : alu_rd;
`else
    logic ldi_unused;

    assign ldi_unused = dec.ldi;
    assign is_alu     = 1'b1;
    assign wr_data    = alu_rd;
`endif

    // Operands are read in the accept cycle; the prior write-back is already committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            alu_rs  <= '0;
            alu_rt  <= '0;
            alu_sel <= '0;
        end else if (accept) begin
            rd_q <= dec.rd_idx;
            if (is_alu) begin
                alu_rs  <= rs_data;
                alu_rt  <= rt_data;
                alu_sel <= dec.sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_idx   <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= commit;
            if (commit) begin
                wb_idx  <= rd_q;
                wb_data <= wr_data;
            end
        end
    end

    alu_issue_regfile #(
        .NREG(NREG),
        .DW  (DW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (commit),
        .wr_idx  (rd_q),
        .wr_data (wr_data),
        .rs_idx  (dec.rs_idx),
        .rt_idx  (dec.rt_idx),
        .dbg_idx (dbg_idx),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .dbg_data(dbg_data)
    );

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Bench for alu_issue_sequencer with a behavioural ALU on the alu_* ports and a write-back scoreboard.
module tb_alu_issue_sequencer;
    import alu_issue_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] instr = '0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] alu_rs, alu_rt, alu_rd;
    logic [2:0] alu_sel;
    logic       wb_valid;
    logic [1:0] wb_idx;
    logic [3:0] wb_data;
    logic [1:0] dbg_idx = '0;
    logic [3:0] dbg_data;

    int checks = 0;
    int failures = 0;
    logic [5:0] exp_q[$];
    logic [5:0] sb_e;

    always #5 clk = ~clk;

    alu_issue_sequencer #(.NREG(4), .DW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .alu_rs     (alu_rs),
        .alu_rt     (alu_rt),
        .alu_sel    (alu_sel),
        .alu_rd     (alu_rd),
        .wb_valid   (wb_valid),
        .wb_idx     (wb_idx),
        .wb_data    (wb_data),
        .dbg_idx    (dbg_idx),
        .dbg_data   (dbg_data)
    );

    // Behavioural ALU: comparisons return {3'b111, eq} and {3'b101, gt}.
    function automatic logic [3:0] alu_f(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        case (s)
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_AND:    return a & b;
            OP_OR:     return a | b;
            OP_ROL_RS: return {a[2:0], a[3]};
            OP_ASR_RT: return {b[3], b[3:1]};
            OP_EQ:     return {3'b111, a == b};
            default:   return {3'b101, a > b};
        endcase
    endfunction

    always_comb alu_rd = alu_f(alu_sel, alu_rs, alu_rt);

    function automatic logic [9:0] mk(input logic [2:0] s, input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
        return {1'b0, s, rd, rs, rt};
    endfunction

    typedef struct {
        logic [9:0] instr;
        logic [2:0] sel;
        logic [1:0] idx;
        logic [3:0] data;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected actual=%0d/%0h required=none", wb_idx, wb_data);
            end else begin
                sb_e = exp_q.pop_front();
                if ({wb_idx, wb_data} !== sb_e) begin
                    failures++;
                    $display("FAIL wb_scoreboard actual=%0d/%0h required=%0d/%0h",
                             wb_idx, wb_data, sb_e[5:4], sb_e[3:0]);
                end
            end
        end
    end

    task automatic issue(input logic [9:0] w, input logic [5:0] e, input bit push);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", instr_ready, 1);
        instr       = w;
        instr_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("sb_drain", exp_q.size(), 0);
    endtask

    task automatic run_vec(input vec_t v, input bit chk_sel, input int id);
        issue(v.instr, {v.idx, v.data}, 1'b1);
        if (chk_sel) chk($sformatf("alu_sel[%0d]", id), alu_sel, v.sel);
        drain();
        dbg_idx = v.idx;
        #1;
        chk($sformatf("dbg_data[%0d]", id), dbg_data, v.data);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [3:0] rdy_seq;
        vec_t v;

        //                 instr                     sel        rd    data
        tbl[0]  = '{mk(OP_EQ,     0, 0, 0), OP_EQ,     2'd0, 4'hF};
        tbl[1]  = '{mk(OP_SUB,    1, 1, 0), OP_SUB,    2'd1, 4'h1};
        tbl[2]  = '{mk(OP_ADD,    2, 1, 1), OP_ADD,    2'd2, 4'h2};
        tbl[3]  = '{mk(OP_ADD,    3, 2, 1), OP_ADD,    2'd3, 4'h3};
        tbl[4]  = '{mk(OP_ADD,    2, 3, 3), OP_ADD,    2'd2, 4'h6};
        tbl[5]  = '{mk(OP_ADD,    2, 2, 3), OP_ADD,    2'd2, 4'h9};
        tbl[6]  = '{mk(OP_ROL_RS, 3, 2, 0), OP_ROL_RS, 2'd3, 4'h3};
        tbl[7]  = '{mk(OP_SUB,    2, 2, 1), OP_SUB,    2'd2, 4'h8};
        tbl[8]  = '{mk(OP_ASR_RT, 3, 0, 2), OP_ASR_RT, 2'd3, 4'hC};
        tbl[9]  = '{mk(OP_GT,     1, 1, 2), OP_GT,     2'd1, 4'hA};
        tbl[10] = '{mk(OP_GT,     3, 3, 2), OP_GT,     2'd3, 4'hB};
        tbl[11] = '{mk(OP_AND,    0, 0, 3), OP_AND,    2'd0, 4'hB};
        tbl[12] = '{mk(OP_OR,     2, 2, 1), OP_OR,     2'd2, 4'hA};
        tbl[13] = '{mk(OP_ADD,    0, 0, 3), OP_ADD,    2'd0, 4'h6};
        tbl[14] = '{mk(OP_SUB,    3, 0, 1), OP_SUB,    2'd3, 4'hC};
        tbl[15] = '{mk(OP_EQ,     1, 1, 2), OP_EQ,     2'd1, 4'hF};
        tbl[16] = '{mk(OP_ASR_RT, 2, 0, 3), OP_ASR_RT, 2'd2, 4'hE};

        // Reset state
        #12;
        chk("rst_ready", instr_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_alu", {alu_rs, alu_rt, alu_sel}, 0);
        chk("rst_wb", {wb_idx, wb_data}, 0);
        for (int r = 0; r < 4; r++) begin
            dbg_idx = 2'(r);
            #1;
            chk($sformatf("rst_reg%0d", r), dbg_data, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", instr_ready, 1);

        for (int i = 0; i < 17; i++) run_vec(tbl[i], 1'b1, i);

        // Back-to-back dependency with instr_valid held high: r0=6, r2=E going in
        @(negedge clk);
        rdy_seq[3]  = instr_ready;
        instr       = mk(OP_OR, 2, 2, 0);
        instr_valid = 1'b1;
        exp_q.push_back({2'd2, 4'hE});
        @(negedge clk);
        rdy_seq[2] = instr_ready;
        instr      = mk(OP_EQ, 3, 2, 2);
        exp_q.push_back({2'd3, 4'hF});
        @(negedge clk);
        rdy_seq[1] = instr_ready;
        @(negedge clk);
        rdy_seq[0]  = instr_ready;
        instr_valid = 1'b0;
        chk("b2b_ready_seq", rdy_seq, 4'b1010);
        drain();
        dbg_idx = 2'd3;
        #1;
        chk("b2b_r3", dbg_data, 4'hF);

        // Reset during EXEC of ADD r1=r0+r0 (r0=6): the write must be aborted
        issue(mk(OP_ADD, 1, 0, 0), '0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready_in_rst", instr_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("abort_ready", instr_ready, 1);
        chk("abort_alu", {alu_rs, alu_rt, alu_sel}, 0);
        for (int r = 0; r < 4; r++) begin
            dbg_idx = 2'(r);
            #1;
            chk($sformatf("abort_reg%0d", r), dbg_data, 0);
        end
        repeat (3) @(negedge clk);
        chk("abort_no_wb", wb_valid, 0);

        // ldi-flagged word with all registers zero: result 0 in either build
        v = '{10'b1_000_01_00_00, OP_ADD, 2'd1, 4'h0};
        run_vec(v, 1'b1, 100);
        run_vec(tbl[0], 1'b1, 101);
`ifdef ALU_ISSUE_LDI_EN
        // Immediate 0 into r1; alu_sel keeps the EQ opcode
        v = '{10'b1_000_01_00_00, OP_EQ, 2'd1, 4'h0};
        run_vec(v, 1'b1, 102);
        v = '{10'b1_000_00_0011, OP_EQ, 2'd0, 4'h3};
        run_vec(v, 1'b1, 103);
        v = '{10'b1_000_01_0101, OP_EQ, 2'd1, 4'h5};
        run_vec(v, 1'b1, 104);
        v = '{mk(OP_ADD, 2, 0, 1), OP_ADD, 2'd2, 4'h8};
        run_vec(v, 1'b1, 105);
        v = '{mk(OP_SUB, 3, 0, 1), OP_SUB, 2'd3, 4'hE};
        run_vec(v, 1'b1, 106);
        v = '{mk(OP_GT, 2, 0, 1), OP_GT, 2'd2, 4'hA};
        run_vec(v, 1'b1, 107);
        v = '{mk(OP_GT, 3, 1, 0), OP_GT, 2'd3, 4'hB};
        run_vec(v, 1'b1, 108);
`else
        // instr[9] ignored: ADD r1 = r0 + r0 = F + F
        v = '{10'b1_000_01_00_00, OP_ADD, 2'd1, 4'hE};
        run_vec(v, 1'b1, 102);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
